mult_div_unit: RTL and testbench

//   Iterative multiply/divide unit that executes the HI/LO-class ALU control codes
//   (OPMULT, OPMULTU, OPDIV, OPDIVU, OPMTHI, OPMTLO, OPMFHI, OPMFLO) issued by the ALU control decode.

---
 rtl/mult_div_unit.sv | 175 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over WIDTH cycles, followed by one sign-fix cycle that writes HI/LO.
module mult_div_unit #(
    parameter int         WIDTH   = 32,
    parameter logic [4:0] OPMULT  = 5'd16,
    parameter logic [4:0] OPMULTU = 5'd17,
    parameter logic [4:0] OPDIV   = 5'd18,
    parameter logic [4:0] OPDIVU  = 5'd19,
    parameter logic [4:0] OPMTHI  = 5'd20,
    parameter logic [4:0] OPMTLO  = 5'd21,
    parameter logic [4:0] OPMFHI  = 5'd22,
    parameter logic [4:0] OPMFLO  = 5'd23
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [4:0]       aluCtrl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q,   state_d;
    logic [CW-1:0]      count_q,   count_d;
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0]   opB_q,     opB_d;
    logic               signA_q,   signA_d;
    logic               signB_q,   signB_d;
    logic               isDivOp_q, isDivOp_d;
    logic               divZero_q, divZero_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               done_q,    done_d;

    logic             isMul, isDiv, isSigned, isHiLo, accept;
    logic             negA, negB;
    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH:0]   mulSum, divShift, divDiff;
    logic             divGe;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient, remainder;

    assign isMul    = (aluCtrl_i == OPMULT) || (aluCtrl_i == OPMULTU);
    assign isDiv    = (aluCtrl_i == OPDIV)  || (aluCtrl_i == OPDIVU);
    assign isSigned = (aluCtrl_i == OPMULT) || (aluCtrl_i == OPDIV);
    assign isHiLo   = isMul || isDiv || (aluCtrl_i == OPMTHI) || (aluCtrl_i == OPMTLO)
                   || (aluCtrl_i == OPMFHI) || (aluCtrl_i == OPMFLO);

    assign busy_o  = (state_q != IDLE);
    assign accept  = valid_i && !busy_o;
    assign stall_o = valid_i && isHiLo && busy_o;
    assign done_o  = done_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    always_comb begin
        if (aluCtrl_i == OPMFHI)      result_o = hi_q;
        else if (aluCtrl_i == OPMFLO) result_o = lo_q;
        else                          result_o = '0;
    end

    assign negA = isSigned && a_i[WIDTH-1];
    assign negB = isSigned && b_i[WIDTH-1];
    assign magA = negA ? -a_i : a_i;
    assign magB = negB ? -b_i : b_i;

    // The accumulator is shared: multiply keeps product-high/multiplier, divide keeps remainder/quotient.
    assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opB_q} : '0);
    assign divShift = acc_q[2*WIDTH-1:WIDTH-1];
    assign divDiff  = divShift - {1'b0, opB_q};
    assign divGe    = (divShift >= {1'b0, opB_q});

    assign product   = (signA_q ^ signB_q) ? -acc_q : acc_q;
    assign quotient  = (signA_q ^ signB_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign remainder = signA_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opB_d     = opB_q;
        signA_d   = signA_q;
        signB_d   = signB_q;
        isDivOp_d = isDivOp_q;
        divZero_d = divZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (isMul || isDiv) begin
                        acc_d     = {{WIDTH{1'b0}}, (isMul ? magB : magA)};
                        opB_d     = isMul ? magA : magB;
                        signA_d   = negA;
                        signB_d   = negB;
                        isDivOp_d = isDiv;
                        divZero_d = (b_i == '0);
                        count_d   = '0;
                        state_d   = isMul ? MUL : DIV;
                    end else if (aluCtrl_i == OPMTHI) begin
                        hi_d = a_i;
                    end else if (aluCtrl_i == OPMTLO) begin
                        lo_d = a_i;
                    end
                end
            end
            MUL: begin
                acc_d   = {mulSum, acc_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == LAST) state_d = FIX;
            end
            DIV: begin
                acc_d   = {(divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0]), acc_q[WIDTH-2:0], divGe};
                count_d = count_q + CW'(1);
                if (count_q == LAST) state_d = FIX;
            end
            FIX: begin
                // A zero divisor leaves the remainder equal to the dividend; only LO needs forcing.
                if (isDivOp_q) begin
                    hi_d = remainder;
                    lo_d = divZero_q ? {WIDTH{1'b1}} : quotient;
                end else begin
                    {hi_d, lo_d} = product;
                end
                done_d  = 1'b1;
                count_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opB_q     <= '0;
            signA_q   <= 1'b0;
            signB_q   <= 1'b0;
            isDivOp_q <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opB_q     <= opB_d;
            signA_q   <= signA_d;
            signB_q   <= signB_d;
            isDivOp_q <= isDivOp_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases with literal expectations, then random
// instruction streams compared every cycle against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int         W       = 32;
    localparam logic [4:0] OPMULT  = 5'd16;
    localparam logic [4:0] OPMULTU = 5'd17;
    localparam logic [4:0] OPDIV   = 5'd18;
    localparam logic [4:0] OPDIVU  = 5'd19;
    localparam logic [4:0] OPMTHI  = 5'd20;
    localparam logic [4:0] OPMTLO  = 5'd21;
    localparam logic [4:0] OPMFHI  = 5'd22;
    localparam logic [4:0] OPMFLO  = 5'd23;

    logic         clk = 1'b0;
    logic         rst, valid;
    logic [4:0]   aluCtrl;
    logic [W-1:0] aIn, bIn;
    logic         busy, stall, done;
    logic [W-1:0] result, hi, lo;

    int total = 0;
    int bad   = 0;
    bit checking = 0;

    logic [W-1:0] mHi, mLo, pHi, pLo;
    int           mLeft = 0;
    logic         mDone;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .aluCtrl_i(aluCtrl),
        .a_i(aIn), .b_i(bIn), .busy_o(busy), .stall_o(stall), .done_o(done),
        .result_o(result), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    function automatic bit isHiLo(input logic [4:0] c);
        return (c >= OPMULT) && (c <= OPMFLO);
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic computeOp(input logic [4:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                             output logic [W-1:0] h, output logic [W-1:0] l);
        longint      sp;
        logic [63:0] up;
        int          sx, sy;
        sx = x;
        sy = y;
        h  = '0;
        l  = '0;
        if (c == OPMULT) begin
            sp = longint'(sx) * longint'(sy);
            {h, l} = sp;
        end else if (c == OPMULTU) begin
            up = {32'b0, x} * {32'b0, y};
            {h, l} = up;
        end else if (y == 0) begin
            h = x;
            l = '1;
        end else if (c == OPDIV) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                h = '0;
                l = x;
            end else begin
                l = sx / sy;
                h = sx % sy;
            end
        end else begin
            l = x / y;
            h = x % y;
        end
    endtask

    // Reference model: an accepted mult/div keeps the unit busy for W+1 cycles, then HI/LO update.
    always @(posedge clk) begin
        if (rst) begin
            mHi = '0; mLo = '0; mLeft = 0; mDone = 1'b0;
        end else begin
            mDone = 1'b0;
            if (mLeft > 0) begin
                mLeft--;
                if (mLeft == 0) begin
                    mHi = pHi; mLo = pLo; mDone = 1'b1;
                end
            end else if (valid) begin
                if (aluCtrl inside {OPMULT, OPMULTU, OPDIV, OPDIVU}) begin
                    computeOp(aluCtrl, aIn, bIn, pHi, pLo);
                    mLeft = W + 1;
                end else if (aluCtrl == OPMTHI) mHi = aIn;
                else if (aluCtrl == OPMTLO) mLo = aIn;
            end
        end
        #1;
        if (checking) begin
            checkOutput("busy", busy, (mLeft > 0));
            checkOutput("done", done, mDone);
            checkOutput("hi", hi, mHi);
            checkOutput("lo", lo, mLo);
            checkOutput("stall", stall, (valid && isHiLo(aluCtrl) && mLeft > 0));
            checkOutput("result", result, (aluCtrl == OPMFHI) ? mHi : (aluCtrl == OPMFLO) ? mLo : '0);
        end
    end

    task automatic applyStimulus(input logic [4:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        valid = 1'b1; aluCtrl = c; aIn = x; bIn = y;
        @(negedge clk);
        valid = 1'b0; aluCtrl = 5'd0; aIn = $urandom; bIn = $urandom;
    endtask

    task automatic waitDone(input string name);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #2;
            seen = done;
        end
        checkOutput(name, seen, 1'b1);
    endtask

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            4:       return -W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; valid = 1'b0; aluCtrl = 5'd0; aIn = '0; bIn = '0;
        @(negedge clk);
        checking = 1;
        checkOutput("rstHi", hi, 0);
        checkOutput("rstLo", lo, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        rst = 1'b0;

        applyStimulus(OPMULT, 7, -32'sd3);
        waitDone("mulTimeout");
        checkOutput("mulHi", hi, 32'hFFFF_FFFF);
        checkOutput("mulLo", lo, 32'hFFFF_FFEB);
        @(posedge clk); #2;
        checkOutput("donePulse", done, 0);

        applyStimulus(OPMULTU, '1, '1);
        waitDone("muluTimeout");
        checkOutput("muluHi", hi, 32'hFFFF_FFFE);
        checkOutput("muluLo", lo, 32'h0000_0001);
        applyStimulus(OPMULT, '1, '1);
        waitDone("mulsTimeout");
        checkOutput("mulsHi", hi, 0);
        checkOutput("mulsLo", lo, 1);

        applyStimulus(OPDIV, -32'sd7, 2);
        waitDone("divTimeout");
        checkOutput("divLo", lo, 32'hFFFF_FFFD);
        checkOutput("divHi", hi, 32'hFFFF_FFFF);
        applyStimulus(OPDIVU, 7, 0);
        waitDone("div0Timeout");
        checkOutput("div0Hi", hi, 7);
        checkOutput("div0Lo", lo, 32'hFFFF_FFFF);
        applyStimulus(OPDIV, 32'h8000_0000, '1);
        waitDone("ovfTimeout");
        checkOutput("ovfHi", hi, 0);
        checkOutput("ovfLo", lo, 32'h8000_0000);

        // MFHI held behind a divide of 100 by -7 (quotient -14, remainder 2).
        applyStimulus(OPDIV, 100, -32'sd7);
        repeat (4) @(negedge clk);
        valid = 1'b1; aluCtrl = OPMFHI;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (done) break;
            checkOutput("mfStall", stall, 1);
        end
        checkOutput("mfDone", done, 1);
        checkOutput("mfResult", result, 2);
        checkOutput("mfNoStall", stall, 0);
        checkOutput("mfLo", lo, 32'hFFFF_FFF2);
        @(negedge clk);
        valid = 1'b0; aluCtrl = 5'd0;

        applyStimulus(OPMTLO, 32'h1234, 0);
        checkOutput("mtloLo", lo, 32'h1234);
        checkOutput("mtloBusy", busy, 0);

        applyStimulus(OPMULT, 3, 5);
        valid = 1'b1; aluCtrl = OPMTHI; aIn = 32'hDEAD;
        @(negedge clk);
        checkOutput("mthiStall", stall, 1);
        checkOutput("mthiHeld", hi, 2);
        valid = 1'b0; aluCtrl = 5'd0;
        waitDone("mthiMulTimeout");
        checkOutput("mthiMulHi", hi, 0);
        checkOutput("mthiMulLo", lo, 15);

        applyStimulus(OPMULT, 7, -32'sd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortHi", hi, 0);
        checkOutput("abortLo", lo, 0);
        checkOutput("abortDone", done, 0);
        rst = 1'b0;
        applyStimulus(OPMULT, 7, -32'sd3);
        waitDone("reMulTimeout");
        checkOutput("reMulHi", hi, 32'hFFFF_FFFF);
        checkOutput("reMulLo", lo, 32'hFFFF_FFEB);

        // Random stream; a stalled instruction is held in EX until it can go.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 799) == 0);
            if (!stall) begin
                valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 9))
                    0:       aluCtrl = $urandom_range(0, 1) ? OPMULT : OPMULTU;
                    1:       aluCtrl = $urandom_range(0, 1) ? OPDIV : OPDIVU;
                    2:       aluCtrl = $urandom_range(0, 1) ? OPMTHI : OPMTLO;
                    3, 4:    aluCtrl = $urandom_range(0, 1) ? OPMFHI : OPMFLO;
                    default: aluCtrl = 5'($urandom_range(0, 15));
                endcase
                aIn = pickOperand();
                bIn = pickOperand();
            end
        end

        @(negedge clk);
        rst = 1'b0; valid = 1'b0; aluCtrl = 5'd0;
        repeat (40) @(negedge clk);
        checkOutput("drainBusy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
